// File: rtl/gate_controller_param_if.sv
// Signal bundle between the keypad/sensor front end and the gate controller.
// The master drives the sensor and PIN inputs; the slave is the controller itself.
interface gate_controller_param_if #(
  parameter int unsigned PIN_W = 8,
  parameter int unsigned CNT_W = 2
);
  logic             Vehiculo;
  logic             Termino;
  logic [PIN_W-1:0] Pin;
  logic             Pin_valid;
  logic             Pin_load;
  logic             Cerrado;
  logic             Abierto;
  logic             Alarma;
  logic             Bloqueo;
  logic [CNT_W-1:0] Intentos;
  logic [1:0]       Estado;

  modport master (
    output Vehiculo, Termino, Pin, Pin_valid, Pin_load,
    input  Cerrado, Abierto, Alarma, Bloqueo, Intentos, Estado
  );

  modport slave (
    input  Vehiculo, Termino, Pin, Pin_valid, Pin_load,
    output Cerrado, Abierto, Alarma, Bloqueo, Intentos, Estado
  );
endinterface

// File: rtl/gate_controller_param.sv
// Parking gate controller: strobed PIN entry, failed-attempt lockout,
// tailgate blocking and an open-gate overtime alarm.
module gate_controller_param #(
  parameter int unsigned          PIN_W        = 8,
  parameter logic [PIN_W-1:0]     PIN_DEFAULT  = 8'h08,
  parameter int unsigned          MAX_FAILS    = 3,
  parameter int unsigned          CNT_W        = 2,
  parameter int unsigned          OPEN_TIMEOUT = 16,
  parameter int unsigned          TMR_W        = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  gate_controller_param_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_BLOCKED = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0] TMO     = TMR_W'(OPEN_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PIN_W-1:0] pin_q, pin_d;

  logic             match;
  logic             mismatch;
  logic             overtime;
  logic [CNT_W-1:0] cnt_inc;

  logic             cerrado;
  logic             abierto;
  logic             alarma;
  logic             bloqueo;
  logic [CNT_W-1:0] intentos;

  assign match    = bus.Pin_valid && (bus.Pin == pin_q);
  assign mismatch = bus.Pin_valid && (bus.Pin != pin_q);
  assign overtime = (tmr_q == TMO);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_CLOSED;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pin_q   <= PIN_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pin_q   <= pin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    pin_d   = pin_q;

    unique case (state_q)
      ST_CLOSED: begin
        if (bus.Pin_valid) begin
          // Entries without a vehicle present are not attempts at all.
          if (bus.Vehiculo) begin
            if (match) begin
              state_d = ST_OPEN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == MAX_CNT) begin
                state_d = ST_LOCKOUT;
              end
            end
          end
        end else if (bus.Pin_load && (cnt_q == '0)) begin
          pin_d = bus.Pin;
        end
      end

      ST_OPEN: begin
        cnt_d = '0;
        if (bus.Termino) begin
          state_d = bus.Vehiculo ? ST_BLOCKED : ST_CLOSED;
        end else if (!overtime) begin
          tmr_d = tmr_q + TMR_W'(1);
        end else begin
          tmr_d = tmr_q;
        end
      end

      ST_BLOCKED: begin
        if (match) begin
          state_d = ST_OPEN;
        end
      end

      ST_LOCKOUT: begin
        if (match) begin
          state_d = ST_CLOSED;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_CLOSED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cerrado  = 1'b0;
    abierto  = 1'b0;
    alarma   = 1'b0;
    bloqueo  = 1'b0;
    intentos = cnt_q;

    unique case (state_q)
      ST_CLOSED: begin
        cerrado = 1'b1;
      end
      ST_OPEN: begin
        abierto = 1'b1;
        alarma  = overtime;
      end
      ST_BLOCKED: begin
        bloqueo = 1'b1;
        alarma  = 1'b1;
      end
      ST_LOCKOUT: begin
        cerrado  = 1'b1;
        alarma   = 1'b1;
        intentos = MAX_CNT;
      end
      default: begin
        cerrado = 1'b1;
      end
    endcase
  end

  assign bus.Cerrado  = cerrado;
  assign bus.Abierto  = abierto;
  assign bus.Alarma   = alarma;
  assign bus.Bloqueo  = bloqueo;
  assign bus.Intentos = intentos;
  assign bus.Estado   = state_q;

endmodule

// File: tb/tb_gate_controller_param.sv
// Directed bench for gate_controller_param: a vector table for single-cycle
// behaviour plus hand-written overtime, timer-restart and reset sequences.
module tb_gate_controller_param;

  logic Clk;
  logic Reset;

  gate_controller_param_if #(.PIN_W(8), .CNT_W(2)) bus ();

  gate_controller_param #(
    .PIN_W       (8),
    .PIN_DEFAULT (8'h08),
    .MAX_FAILS   (3),
    .CNT_W       (2),
    .OPEN_TIMEOUT(16),
    .TMR_W       (5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       veh;
    logic       ter;
    logic [7:0] pin;
    logic       pv;
    logic       pl;
    logic [1:0] est;
    logic       cer;
    logic       abi;
    logic       ala;
    logic       blo;
    logic [1:0] intn;
  } vec_t;

  localparam int unsigned NVEC = 34;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic rst, input logic veh, input logic ter,
                              input logic [7:0] pin, input logic pv, input logic pl,
                              input logic [1:0] est, input logic cer, input logic abi,
                              input logic ala, input logic blo, input logic [1:0] intn);
    vec_t v;
    v.rst = rst; v.veh = veh; v.ter = ter; v.pin = pin; v.pv = pv; v.pl = pl;
    v.est = est; v.cer = cer; v.abi = abi; v.ala = ala; v.blo = blo; v.intn = intn;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic veh, input logic ter,
                       input logic [7:0] pin, input logic pv, input logic pl);
    @(negedge Clk);
    Reset         = rst;
    bus.Vehiculo  = veh;
    bus.Termino   = ter;
    bus.Pin       = pin;
    bus.Pin_valid = pv;
    bus.Pin_load  = pl;
    @(posedge Clk);
    #1;
  endtask

  // Packed as {Estado, Cerrado, Abierto, Alarma, Bloqueo, Intentos}.
  task automatic check(input string name, input logic [1:0] est, input logic cer,
                       input logic abi, input logic ala, input logic blo,
                       input logic [1:0] intn);
    logic [7:0] got;
    logic [7:0] exp;
    got = {bus.Estado, bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo, bus.Intentos};
    exp = {est, cer, abi, ala, blo, intn};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got est=%0d cer=%b abi=%b ala=%b blo=%b int=%0d, want est=%0d cer=%b abi=%b ala=%b blo=%b int=%0d",
               name, got[7:6], got[5], got[4], got[3], got[2], got[1:0],
               est, cer, abi, ala, blo, intn);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Vehiculo = 1'b0; bus.Termino = 1'b0; bus.Pin = '0;
    bus.Pin_valid = 1'b0; bus.Pin_load = 1'b0;

    //               rst veh ter pin    pv pl   est cer abi ala blo int
    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0); // reset
    vecs[1]  = mk(0, 1, 0, 8'h08, 1, 0,  1, 0, 1, 0, 0, 0); // open
    vecs[2]  = mk(0, 0, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0); // close
    vecs[3]  = mk(0, 1, 0, 8'h11, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 0, 8'h22, 1, 0,  0, 1, 0, 0, 0, 2);
    vecs[5]  = mk(0, 1, 0, 8'h33, 1, 0,  3, 1, 0, 1, 0, 3); // lockout
    vecs[6]  = mk(0, 1, 0, 8'h44, 1, 0,  3, 1, 0, 1, 0, 3); // saturate
    vecs[7]  = mk(0, 0, 0, 8'h08, 1, 0,  0, 1, 0, 0, 0, 0); // unlock, veh dc
    vecs[8]  = mk(0, 0, 0, 8'h11, 1, 0,  0, 1, 0, 0, 0, 0); // no vehicle
    vecs[9]  = mk(0, 1, 0, 8'h08, 1, 0,  1, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 1, 1, 8'h00, 0, 0,  2, 0, 0, 1, 1, 0); // tailgate
    vecs[11] = mk(0, 1, 0, 8'h22, 1, 0,  2, 0, 0, 1, 1, 0); // no count
    vecs[12] = mk(0, 1, 0, 8'h08, 1, 0,  1, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 8'h5A, 0, 1,  0, 1, 0, 0, 0, 0); // load 5A
    vecs[15] = mk(0, 1, 0, 8'h08, 1, 0,  0, 1, 0, 0, 0, 1); // old pin fails
    vecs[16] = mk(0, 1, 0, 8'h5A, 1, 0,  1, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 8'h77, 1, 1,  0, 1, 0, 0, 0, 0); // load dropped
    vecs[19] = mk(0, 1, 0, 8'h77, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 8'h5A, 1, 0,  1, 0, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[22] = mk(0, 1, 0, 8'h11, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 8'h33, 0, 1,  0, 1, 0, 0, 0, 1); // cnt!=0: no load
    vecs[24] = mk(0, 1, 0, 8'h33, 1, 0,  0, 1, 0, 0, 0, 2);
    vecs[25] = mk(0, 1, 0, 8'h5A, 1, 0,  1, 0, 1, 0, 0, 0);
    vecs[26] = mk(0, 1, 0, 8'h11, 1, 0,  1, 0, 1, 0, 0, 0); // pv ignored
    vecs[27] = mk(0, 0, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[28] = mk(0, 1, 0, 8'h11, 1, 0,  0, 1, 0, 0, 0, 1);
    vecs[29] = mk(0, 1, 0, 8'h22, 1, 0,  0, 1, 0, 0, 0, 2);
    vecs[30] = mk(0, 1, 0, 8'h33, 1, 0,  3, 1, 0, 1, 0, 3);
    vecs[31] = mk(1, 1, 0, 8'h5A, 1, 0,  0, 1, 0, 0, 0, 0); // reset in lockout
    vecs[32] = mk(0, 1, 0, 8'h5A, 1, 0,  0, 1, 0, 0, 0, 1); // pin back to 08
    vecs[33] = mk(0, 1, 0, 8'h08, 1, 0,  1, 0, 1, 0, 0, 0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].veh, vecs[i].ter, vecs[i].pin, vecs[i].pv, vecs[i].pl);
      check($sformatf("vec%0d", i), vecs[i].est, vecs[i].cer, vecs[i].abi,
            vecs[i].ala, vecs[i].blo, vecs[i].intn);
    end

    // Overtime: alarm on the 16th open cycle, then saturates while open.
    for (int k = 1; k <= 19; k++) begin
      drive(0, 0, 0, 8'h00, 0, 0);
      check($sformatf("overtime_k%0d", k), 1, 0, 1, (k >= 16), 0, 0);
    end
    drive(0, 0, 1, 8'h00, 0, 0);
    check("overtime_close", 0, 1, 0, 0, 0, 0);

    // Timer restart after BLOCKED, with a non-default PIN loaded.
    drive(0, 0, 0, 8'h5A, 0, 1);
    check("load5A_b", 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 8'h5A, 1, 0);
    check("open5A_b", 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 8'h00, 0, 0);
      check($sformatf("pre_blk_k%0d", k), 1, 0, 1, 0, 0, 0);
    end
    drive(0, 1, 1, 8'h00, 0, 0);
    check("tailgate_b", 2, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 8'h5A, 1, 0);
    check("reopen_b", 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      drive(0, 0, 0, 8'h00, 0, 0);
      check($sformatf("restart_k%0d", k), 1, 0, 1, (k >= 16), 0, 0);
    end

    // Reset while open with overtime restores the default PIN.
    drive(1, 0, 0, 8'h00, 0, 0);
    check("reset_overtime", 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 8'h08, 1, 0);
    check("default_pin_open", 1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 8'h00, 0, 0);
    check("final_close", 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
